// File: rtl/m_trap_sequencer_pkg.sv
// Shared constants and types for the machine-mode trap/MRET sequencer.
// CSR addresses, mstatus bit positions, state and selection encodings.
package m_trap_sequencer_pkg;

  localparam logic [1:0] XLEN_32b = 2'd1;
  localparam logic [1:0] XLEN_64b = 2'd2;

  // Reserved cause code, never raised by the pipeline.
  localparam logic [3:0] NO_E = 4'd10;

  localparam logic [11:0] REG_MSTATUS_ADDR = 12'h300;
  localparam logic [11:0] REG_MTVEC_ADDR   = 12'h305;
  localparam logic [11:0] REG_MEPC_ADDR    = 12'h341;
  localparam logic [11:0] REG_MCAUSE_ADDR  = 12'h342;
  localparam logic [11:0] REG_MTVAL_ADDR   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_WR_MEPC,
    TS_WR_MCAUSE,
    TS_WR_MTVAL,
    TS_WR_MSTATUS,
    TS_REDIRECT,
    TS_MRET_MSTATUS,
    TS_MRET_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_EM,
    SEL_MRET,
    SEL_FD
  } trap_sel_e;

  function automatic int xlen_bits(input logic [1:0] code);
    return 1 << (int'(code) + 4);
  endfunction

endpackage

// File: rtl/m_trap_sequencer_arbiter.sv
// Combinational arbiter: E/M exception > MRET > F/D exception.
// Ports: three event sources in; sel, code, pc, tval of the winner out.
module m_trap_arbiter
  import m_trap_sequencer_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   i_code_f_d,
  input  logic [W-1:0] i_pc_f_d,
  input  logic [3:0]   i_code_e_m,
  input  logic [W-1:0] i_pc_e_m,
  input  logic [W-1:0] i_addr_e_m,
  input  logic         i_mret,
  output trap_sel_e    o_sel,
  output logic [3:0]   o_code,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_tval
);

  logic em_v;
  logic mret_v;
  logic fd_v;

  // One-hot winners so the decoder below is truly unique.
  assign em_v   = (i_code_e_m != NO_E);
  assign mret_v = i_mret & ~em_v;
  assign fd_v   = (i_code_f_d != NO_E) & ~em_v & ~i_mret;

  always_comb begin
    o_sel  = SEL_NONE;
    o_code = NO_E;
    o_pc   = '0;
    o_tval = '0;
    unique case (1'b1)
      em_v: begin
        o_sel  = SEL_EM;
        o_code = i_code_e_m;
        o_pc   = i_pc_e_m;
        o_tval = i_addr_e_m;
      end
      mret_v: o_sel = SEL_MRET;
      fd_v: begin
        o_sel  = SEL_FD;
        o_code = i_code_f_d;
        o_pc   = i_pc_f_d;
        o_tval = i_pc_f_d;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_trap_sequencer.sv
// Machine-mode trap/MRET sequencer driving the M-CSR file write port.
// Ports: event sources and CSR read data in; CSR port, stall, flush, redirect out.
module m_trap_sequencer
  import m_trap_sequencer_pkg::*;
#(
  parameter logic [1:0] XLEN = XLEN_64b,
  localparam int W = xlen_bits(XLEN)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_en,
  input  logic [3:0]   i_exception_code_f_d_ff,
  input  logic [W-1:0] i_exception_pc_f_d_ff,
  input  logic [3:0]   i_exception_code_e_m_ff,
  input  logic [W-1:0] i_exception_pc_e_m_ff,
  input  logic [W-1:0] i_exception_addr_e_m_ff,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_csr_rdata,
  input  logic [W-1:0] i_mepc,
  output logic [11:0]  o_csr_read_addr,
  output logic [11:0]  o_csr_write_addr,
  output logic         o_csr_write_enable,
  output logic [W-1:0] o_csr_data,
  output logic         o_busy,
  output logic         o_stall,
  output logic         o_flush,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc
);

  localparam logic [W-1:0] ALIGN = {{(W-2){1'b1}}, 2'b00};

  trap_state_e  state_q;
  trap_sel_e    sel;
  logic [3:0]   a_code;
  logic [W-1:0] a_pc;
  logic [W-1:0] a_tval;
  logic [3:0]   cause_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] tval_q;
  logic [W-1:0] target_q;
  logic [W-1:0] mst_trap;
  logic [W-1:0] mst_mret;
  logic         event_idle;

  m_trap_arbiter #(.W(W)) u_arb (
    .i_code_f_d (i_exception_code_f_d_ff),
    .i_pc_f_d   (i_exception_pc_f_d_ff),
    .i_code_e_m (i_exception_code_e_m_ff),
    .i_pc_e_m   (i_exception_pc_e_m_ff),
    .i_addr_e_m (i_exception_addr_e_m_ff),
    .i_mret     (i_mret_e),
    .o_sel      (sel),
    .o_code     (a_code),
    .o_pc       (a_pc),
    .o_tval     (a_tval)
  );

  // Stall covers the detect cycle so nothing advances before capture.
  assign event_idle = ~i_rst & (state_q == TS_IDLE) & (sel != SEL_NONE);
  assign o_stall    = o_busy | event_idle;

  always_comb begin
    mst_trap = i_csr_rdata;
    mst_trap[MSTATUS_MPIE] = i_csr_rdata[MSTATUS_MIE];
    mst_trap[MSTATUS_MIE]  = 1'b0;
    mst_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mst_mret = i_csr_rdata;
    mst_mret[MSTATUS_MIE]  = i_csr_rdata[MSTATUS_MPIE];
    mst_mret[MSTATUS_MPIE] = 1'b1;
    mst_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  // mstatus is read-modify-write in one cycle, so its data stays combinational.
  always_comb begin
    o_csr_data = '0;
    unique case (state_q)
      TS_WR_MEPC:      o_csr_data = pc_q;
      TS_WR_MCAUSE:    o_csr_data = {{(W-4){1'b0}}, cause_q};
      TS_WR_MTVAL:     o_csr_data = tval_q;
      TS_WR_MSTATUS:   o_csr_data = mst_trap;
      TS_MRET_MSTATUS: o_csr_data = mst_mret;
      default:         o_csr_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q            <= TS_IDLE;
      cause_q            <= '0;
      pc_q               <= '0;
      tval_q             <= '0;
      target_q           <= '0;
      o_csr_read_addr    <= '0;
      o_csr_write_addr   <= '0;
      o_csr_write_enable <= 1'b0;
      o_busy             <= 1'b0;
      o_flush            <= 1'b0;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= '0;
    end else if (i_clk_en) begin
      o_flush          <= 1'b0;
      o_redirect_valid <= 1'b0;
      unique case (state_q)
        TS_IDLE: begin
          if (sel == SEL_EM || sel == SEL_FD) begin
            cause_q            <= a_code;
            pc_q               <= a_pc;
            tval_q             <= a_tval;
            state_q            <= TS_WR_MEPC;
            o_busy             <= 1'b1;
            o_csr_write_enable <= 1'b1;
            o_csr_write_addr   <= REG_MEPC_ADDR;
            o_csr_read_addr    <= REG_MTVEC_ADDR;
          end else if (sel == SEL_MRET) begin
            state_q            <= TS_MRET_MSTATUS;
            o_busy             <= 1'b1;
            o_csr_write_enable <= 1'b1;
            o_csr_write_addr   <= REG_MSTATUS_ADDR;
            o_csr_read_addr    <= REG_MSTATUS_ADDR;
          end
        end
        TS_WR_MEPC: begin
          // Direct mode only: low mtvec bits are the mode field.
          target_q         <= i_csr_rdata & ALIGN;
          state_q          <= TS_WR_MCAUSE;
          o_csr_write_addr <= REG_MCAUSE_ADDR;
          o_csr_read_addr  <= '0;
        end
        TS_WR_MCAUSE: begin
          state_q          <= TS_WR_MTVAL;
          o_csr_write_addr <= REG_MTVAL_ADDR;
        end
        TS_WR_MTVAL: begin
          state_q          <= TS_WR_MSTATUS;
          o_csr_write_addr <= REG_MSTATUS_ADDR;
          o_csr_read_addr  <= REG_MSTATUS_ADDR;
        end
        TS_WR_MSTATUS: begin
          state_q            <= TS_REDIRECT;
          o_csr_write_enable <= 1'b0;
          o_csr_write_addr   <= '0;
          o_csr_read_addr    <= '0;
          o_flush            <= 1'b1;
          o_redirect_valid   <= 1'b1;
          o_redirect_pc      <= target_q;
        end
        TS_MRET_MSTATUS: begin
          state_q            <= TS_MRET_REDIRECT;
          o_csr_write_enable <= 1'b0;
          o_csr_write_addr   <= '0;
          o_csr_read_addr    <= '0;
          o_flush            <= 1'b1;
          o_redirect_valid   <= 1'b1;
          o_redirect_pc      <= i_mepc & ALIGN;
        end
        TS_REDIRECT, TS_MRET_REDIRECT: begin
          state_q       <= TS_IDLE;
          o_busy        <= 1'b0;
          o_redirect_pc <= '0;
        end
        default: state_q <= TS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_trap_sequencer.sv
// Bench for m_trap_sequencer: 32- and 64-bit instances, vector table,
// write/redirect scoreboard, clock-enable and mid-sequence reset sequences.
module tb_m_trap_sequencer;
  import m_trap_sequencer_pkg::*;

  typedef struct {
    bit          use32;
    logic [3:0]  em_code;
    logic [63:0] em_pc;
    logic [63:0] em_addr;
    logic [3:0]  fd_code;
    logic [63:0] fd_pc;
    bit          mret;
    logic [63:0] mtvec;
    logic [63:0] mstatus;
    logic [63:0] mepc;
    bit          exp_mret;
    logic [3:0]  exp_cause;
    logic [63:0] exp_pc;
    logic [63:0] exp_tval;
    logic [63:0] exp_mst;
    logic [63:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [63:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [3:0]  fd_code;
  logic [63:0] fd_pc;
  logic [3:0]  em_code;
  logic [63:0] em_pc;
  logic [63:0] em_addr;
  logic        mret;
  logic [63:0] mtvec_m;
  logic [63:0] mst_m;
  logic [63:0] mepc_m;
  bit          use32;

  logic [63:0] rdata64;
  logic [11:0] o64_raddr, o64_waddr;
  logic        o64_we, o64_busy, o64_stall, o64_flush, o64_rv;
  logic [63:0] o64_data, o64_rpc;

  logic [31:0] rdata32;
  logic [11:0] o32_raddr, o32_waddr;
  logic        o32_we, o32_busy, o32_stall, o32_flush, o32_rv;
  logic [31:0] o32_data, o32_rpc;

  logic [11:0] mon_waddr;
  logic        mon_we, mon_busy, mon_stall, mon_flush, mon_rv;
  logic [63:0] mon_data, mon_rpc;

  int   checks = 0;
  int   failures = 0;
  wr_t  wq[$];
  logic [63:0] rq[$];
  wr_t  mon_e;
  vec_t vecs[8];

  always #5 clk = ~clk;

  assign rdata64 = (o64_raddr == REG_MTVEC_ADDR)   ? mtvec_m :
                   (o64_raddr == REG_MSTATUS_ADDR) ? mst_m : 64'h0;
  assign rdata32 = (o32_raddr == REG_MTVEC_ADDR)   ? mtvec_m[31:0] :
                   (o32_raddr == REG_MSTATUS_ADDR) ? mst_m[31:0] : 32'h0;

  m_trap_sequencer #(.XLEN(XLEN_64b)) dut64 (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_clk_en                (clk_en),
    .i_exception_code_f_d_ff (fd_code),
    .i_exception_pc_f_d_ff   (fd_pc),
    .i_exception_code_e_m_ff (em_code),
    .i_exception_pc_e_m_ff   (em_pc),
    .i_exception_addr_e_m_ff (em_addr),
    .i_mret_e                (mret),
    .i_csr_rdata             (rdata64),
    .i_mepc                  (mepc_m),
    .o_csr_read_addr         (o64_raddr),
    .o_csr_write_addr        (o64_waddr),
    .o_csr_write_enable      (o64_we),
    .o_csr_data              (o64_data),
    .o_busy                  (o64_busy),
    .o_stall                 (o64_stall),
    .o_flush                 (o64_flush),
    .o_redirect_valid        (o64_rv),
    .o_redirect_pc           (o64_rpc)
  );

  m_trap_sequencer #(.XLEN(XLEN_32b)) dut32 (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_clk_en                (clk_en),
    .i_exception_code_f_d_ff (fd_code),
    .i_exception_pc_f_d_ff   (fd_pc[31:0]),
    .i_exception_code_e_m_ff (em_code),
    .i_exception_pc_e_m_ff   (em_pc[31:0]),
    .i_exception_addr_e_m_ff (em_addr[31:0]),
    .i_mret_e                (mret),
    .i_csr_rdata             (rdata32),
    .i_mepc                  (mepc_m[31:0]),
    .o_csr_read_addr         (o32_raddr),
    .o_csr_write_addr        (o32_waddr),
    .o_csr_write_enable      (o32_we),
    .o_csr_data              (o32_data),
    .o_busy                  (o32_busy),
    .o_stall                 (o32_stall),
    .o_flush                 (o32_flush),
    .o_redirect_valid        (o32_rv),
    .o_redirect_pc           (o32_rpc)
  );

  assign mon_waddr = use32 ? o32_waddr : o64_waddr;
  assign mon_we    = use32 ? o32_we    : o64_we;
  assign mon_data  = use32 ? {32'h0, o32_data} : o64_data;
  assign mon_busy  = use32 ? o32_busy  : o64_busy;
  assign mon_stall = use32 ? o32_stall : o64_stall;
  assign mon_flush = use32 ? o32_flush : o64_flush;
  assign mon_rv    = use32 ? o32_rv    : o64_rv;
  assign mon_rpc   = use32 ? {32'h0, o32_rpc} : o64_rpc;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    fd_code = NO_E;
    em_code = NO_E;
    mret    = 1'b0;
    fd_pc   = '0;
    em_pc   = '0;
    em_addr = '0;
  endtask

  // Scoreboard: each enabled write strobe and each redirect pops one entry.
  always @(negedge clk) begin
    if (mon_we && clk_en) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required=none",
                 mon_waddr, mon_data);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_addr", {52'h0, mon_waddr}, {52'h0, mon_e.a});
        chk("wr_data", mon_data, mon_e.d);
      end
    end
    if ((mon_flush || mon_rv) && clk_en) begin
      chk("flush", {63'h0, mon_flush}, 64'h1);
      chk("redirect_valid", {63'h0, mon_rv}, 64'h1);
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect pc=%h required=none", mon_rpc);
      end else begin
        chk("redirect_pc", mon_rpc, rq.pop_front());
      end
    end
  end

  task automatic push_trap(input logic [63:0] pc, input logic [3:0] c,
                           input logic [63:0] tv);
    wq.push_back('{REG_MEPC_ADDR, pc});
    wq.push_back('{REG_MCAUSE_ADDR, {60'h0, c}});
    wq.push_back('{REG_MTVAL_ADDR, tv});
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    step();
    use32   = v.use32;
    em_code = v.em_code;
    em_pc   = v.em_pc;
    em_addr = v.em_addr;
    fd_code = v.fd_code;
    fd_pc   = v.fd_pc;
    mret    = v.mret;
    mtvec_m = v.mtvec;
    mst_m   = v.mstatus;
    mepc_m  = v.mepc;
    if (!v.exp_mret) push_trap(v.exp_pc, v.exp_cause, v.exp_tval);
    wq.push_back('{REG_MSTATUS_ADDR, v.exp_mst});
    rq.push_back(v.exp_rpc);
    #1;
    chk("detect_stall", {63'h0, mon_stall}, 64'h1);
    chk("detect_not_busy", {63'h0, mon_busy}, 64'h0);
    step();
    clear_ev();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mon_busy) break;
      cnt++;
      step();
    end
    chk("busy_cycles", 64'(cnt), v.exp_mret ? 64'd2 : 64'd5);
    chk("writes_left", 64'(wq.size()), 64'd0);
    chk("redirects_left", 64'(rq.size()), 64'd0);
    chk("idle_stall", {63'h0, mon_stall}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd5, 64'h100, 64'h2003, NO_E, 64'h0, 1'b0,
                64'h8001, 64'h8, 64'h0,
                1'b0, 4'd5, 64'h100, 64'h2003, 64'h1880, 64'h8000};
    vecs[1] = '{1'b0, 4'd7, 64'h300, 64'h44, 4'd2, 64'h200, 1'b0,
                64'h1000, 64'h0, 64'h0,
                1'b0, 4'd7, 64'h300, 64'h44, 64'h1800, 64'h1000};
    vecs[2] = '{1'b0, NO_E, 64'h0, 64'h0, NO_E, 64'h0, 1'b1,
                64'h0, 64'h1880, 64'h104,
                1'b1, 4'd0, 64'h0, 64'h0, 64'h88, 64'h104};
    vecs[3] = '{1'b0, NO_E, 64'h0, 64'h0, 4'd1, 64'hFFFF_0000_0000_0004,
                1'b0, 64'h8000_0000_0000_0103, 64'h0000_000A_0000_0008,
                64'h0, 1'b0, 4'd1, 64'hFFFF_0000_0000_0004,
                64'hFFFF_0000_0000_0004, 64'h0000_000A_0000_1880,
                64'h8000_0000_0000_0100};
    vecs[4] = '{1'b0, NO_E, 64'h0, 64'h0, 4'd3, 64'h600, 1'b1,
                64'h0, 64'h1808, 64'h2002,
                1'b1, 4'd0, 64'h0, 64'h0, 64'h80, 64'h2000};
    vecs[5] = '{1'b0, 4'd11, 64'h400, 64'h0, NO_E, 64'h0, 1'b1,
                64'h500, 64'h80, 64'h999,
                1'b0, 4'd11, 64'h400, 64'h0, 64'h1800, 64'h500};
    vecs[6] = '{1'b1, NO_E, 64'h0, 64'h0, NO_E, 64'h0, 1'b1,
                64'h0, 64'h0, 64'h10,
                1'b1, 4'd0, 64'h0, 64'h0, 64'h80, 64'h10};
    vecs[7] = '{1'b1, NO_E, 64'h0, 64'h0, 4'd2, 64'hFF0, 1'b0,
                64'h7FFF_FFFD, 64'hFFFF_FFFF, 64'h0,
                1'b0, 4'd2, 64'hFF0, 64'hFF0, 64'hFFFF_FFF7, 64'h7FFF_FFFC};

    rst = 1'b1;
    clk_en = 1'b1;
    use32 = 1'b0;
    mtvec_m = '0;
    mst_m = '0;
    mepc_m = '0;
    clear_ev();
    step();
    step();
    chk("rst64_ctrl", {59'h0, o64_we, o64_busy, o64_stall, o64_flush, o64_rv}, 64'h0);
    chk("rst64_addr", {40'h0, o64_raddr, o64_waddr}, 64'h0);
    chk("rst64_data", o64_data | o64_rpc, 64'h0);
    chk("rst32_ctrl", {59'h0, o32_we, o32_busy, o32_stall, o32_flush, o32_rv}, 64'h0);
    chk("rst32_data", {32'h0, o32_data | o32_rpc}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Clock enable held low for three cycles while in WR_MCAUSE.
    use32 = 1'b0;
    step();
    em_code = 4'd13;
    em_pc   = 64'h700;
    em_addr = 64'h7777;
    mtvec_m = 64'h40;
    mst_m   = 64'h8;
    push_trap(64'h700, 4'd13, 64'h7777);
    wq.push_back('{REG_MSTATUS_ADDR, 64'h1880});
    rq.push_back(64'h40);
    step();
    clear_ev();
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_waddr", {52'h0, o64_waddr}, {52'h0, REG_MCAUSE_ADDR});
      chk("hold_we", {63'h0, o64_we}, 64'h1);
      chk("hold_data", o64_data, 64'd13);
      chk("hold_busy", {62'h0, o64_busy, o64_stall}, 64'h3);
    end
    clk_en = 1'b1;
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        if (!o64_busy) break;
        cnt++;
        step();
      end
      chk("resume_busy_cycles", 64'(cnt), 64'd4);
    end
    chk("ce_writes_left", 64'(wq.size()), 64'd0);
    chk("ce_redirects_left", 64'(rq.size()), 64'd0);

    // Reset asserted mid-sequence while in WR_MTVAL.
    step();
    em_code = 4'd4;
    em_pc   = 64'h900;
    em_addr = 64'h901;
    push_trap(64'h900, 4'd4, 64'h901);
    step();
    clear_ev();
    step();
    step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ctrl", {59'h0, o64_we, o64_busy, o64_stall, o64_flush, o64_rv}, 64'h0);
    chk("arst_addr", {40'h0, o64_raddr, o64_waddr}, 64'h0);
    chk("arst_data", o64_data | o64_rpc, 64'h0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_rst_idle", {62'h0, o64_busy, o64_stall}, 64'h0);
    chk("rst_writes_left", 64'(wq.size()), 64'd0);
    chk("rst_redirects_left", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
